// File: rtl/buffer_pkg.sv
// Sample buffer timestamp layout: {time, index}, index in the low bits.
package buffer_pkg;
    localparam int TSTAMP_WIDTH       = 48;
    localparam int SAMPLE_INDEX_WIDTH = 16;
    localparam int TIME_WIDTH         = TSTAMP_WIDTH - SAMPLE_INDEX_WIDTH;

    typedef struct packed {
        logic [TIME_WIDTH-1:0]         time_val;
        logic [SAMPLE_INDEX_WIDTH-1:0] index;
    } tstamp_t;
endpackage

// File: rtl/rx_pkg.sv
// Receive-path constants shared by the per-channel readout blocks.
package rx_pkg;
    localparam int CHANNELS         = 2;
    localparam int SAMPLE_WIDTH     = 16;
    localparam int PARALLEL_SAMPLES = 4;
    localparam int DATA_WIDTH       = SAMPLE_WIDTH * PARALLEL_SAMPLES;
endpackage

// File: rtl/sample_reconstructor_pkg.sv
// Types and helpers for sample_reconstructor (optional macro SAMPLE_RECONSTRUCTOR_HOLD_EN).
package sample_reconstructor_pkg;
    localparam int SR_DW = rx_pkg::DATA_WIDTH;
    localparam int SR_SW = rx_pkg::SAMPLE_WIDTH;
    localparam int SR_NS = rx_pkg::PARALLEL_SAMPLES;
    localparam int SR_TW = buffer_pkg::TIME_WIDTH;

    typedef struct packed {
        logic [SR_DW-1:0] data;
        logic             last;
        logic             fill;
    } beat_t;

    function automatic logic [SR_DW-1:0] replicate_sample(input logic [SR_SW-1:0] smp);
        logic [SR_DW-1:0] r;
        r = '0;
        for (int i = 0; i < SR_NS; i++) begin
            r[i*SR_SW +: SR_SW] = smp;
        end
        return r;
    endfunction

    // A gap is unusable if it is negative (overlap) or not a whole number of batches.
    function automatic logic gap_invalid(input logic [SR_TW-1:0] delta, input logic [SR_TW-1:0] dec);
        return delta[SR_TW-1] || ((dec != '0) && ((delta % dec) != '0));
    endfunction
endpackage

// File: rtl/sample_reconstructor_out_reg.sv
// Single-stage AXIS output register shared by the passthrough and filler paths.
module sample_reconstructor_out_reg
    import sample_reconstructor_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  in_valid_i,
    input  beat_t in_beat_i,
    output logic  in_ready_o,
    output logic  out_valid_o,
    output beat_t out_beat_o,
    input  logic  out_ready_i
);
    logic  valid_q;
    beat_t beat_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_beat_o  = beat_q;

    // Load whenever the stage is empty or its beat leaves this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                beat_q <= in_beat_i;
            end
        end
    end
endmodule

// File: rtl/sample_reconstructor.sv
// Gap-filling rebuild of a sparse sample stream for one channel.
// Define SAMPLE_RECONSTRUCTOR_HOLD_EN to fill gaps with the last passed sample instead of zeros.
module sample_reconstructor
    import sample_reconstructor_pkg::*;
#(
    parameter int MAX_DECIMATION = 64
) (
    input  logic                                   ps_clk,
    input  logic                                   ps_reset,
    input  logic [$clog2(MAX_DECIMATION+1)-1:0]    cfg_decimation,
    input  logic [buffer_pkg::TSTAMP_WIDTH-1:0]    s_tstamp_data,
    input  logic                                   s_tstamp_valid,
    input  logic                                   s_tstamp_last,
    output logic                                   s_tstamp_ready,
    input  logic [rx_pkg::DATA_WIDTH-1:0]          s_data_data,
    input  logic                                   s_data_valid,
    input  logic                                   s_data_last,
    output logic                                   s_data_ready,
    output logic [rx_pkg::DATA_WIDTH-1:0]          m_data_data,
    output logic                                   m_data_valid,
    output logic                                   m_data_last,
    output logic                                   m_data_fill,
    input  logic                                   m_data_ready,
    output logic                                   error
);
    localparam int DEC_W = $clog2(MAX_DECIMATION+1);
    localparam int TW    = buffer_pkg::TIME_WIDTH;
    localparam int IW    = buffer_pkg::SAMPLE_INDEX_WIDTH;
    localparam int DW    = rx_pkg::DATA_WIDTH;
    localparam int SW    = rx_pkg::SAMPLE_WIDTH;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PEEK = 3'd1,
        PASS = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                state_q;
    logic                  arm_q;
    logic                  first_q;
    logic [DEC_W-1:0]      dec_q;
    buffer_pkg::tstamp_t   cur_q;
    buffer_pkg::tstamp_t   nxt_q;
    buffer_pkg::tstamp_t   ts_in_s;
    logic                  cur_last_q;
    logic                  nxt_valid_q;
    logic                  nxt_last_q;
    logic [TW-1:0]         exp_time_q;
    logic [IW-1:0]         sample_count_q;
    logic                  error_q;
    logic                  ts_done_q;
    logic                  data_done_q;

    logic [TW-1:0]         delta_s;
    logic [TW-1:0]         dec_time_s;
    logic [IW-1:0]         count_inc_s;
    logic                  run_end_s;
    logic                  gap_bad_s;
    logic                  gap_done_s;
    logic                  ts_ready_s;
    logic                  data_ready_s;
    logic                  ts_hs_s;
    logic                  data_hs_s;
    logic                  ov_valid_s;
    logic                  ov_ready_s;
    beat_t                 ov_beat_s;
    beat_t                 out_beat_s;
    logic [DW-1:0]         fill_data_s;

    assign ts_in_s     = s_tstamp_data;
    assign dec_time_s  = TW'(dec_q);
    assign delta_s     = nxt_q.time_val - exp_time_q;
    assign count_inc_s = sample_count_q + IW'(1);
    assign run_end_s   = nxt_valid_q && (sample_count_q == nxt_q.index);
    assign gap_bad_s   = gap_invalid(delta_s, dec_time_s);
    assign gap_done_s  = (delta_s == '0) || gap_bad_s;
    assign ts_hs_s     = s_tstamp_valid && ts_ready_s;
    assign data_hs_s   = s_data_valid && data_ready_s;

    assign s_tstamp_ready = ts_ready_s;
    assign s_data_ready   = data_ready_s;
    assign error          = error_q;
    assign m_data_data    = out_beat_s.data;
    assign m_data_last    = out_beat_s.last;
    assign m_data_fill    = out_beat_s.fill;

`ifdef SAMPLE_RECONSTRUCTOR_HOLD_EN
    logic [SW-1:0] hold_q;

    // Newest sample of the most recent passed batch, replicated into filler.
    always_ff @(posedge ps_clk) begin
        if (ps_reset) begin
            hold_q <= '0;
        end else if (data_hs_s && (state_q == PASS)) begin
            hold_q <= s_data_data[DW-1 -: SW];
        end
    end
    assign fill_data_s = replicate_sample(hold_q);
`else
    assign fill_data_s = {DW{1'b0}};
`endif

    // Handshake decode and the beat offered to the output register.
    always_comb begin
        ts_ready_s   = 1'b0;
        data_ready_s = 1'b0;
        ov_valid_s   = 1'b0;
        ov_beat_s    = '0;
        case (state_q)
            IDLE: ts_ready_s = arm_q;
            PEEK: ts_ready_s = !cur_last_q && !nxt_valid_q;
            PASS: begin
                data_ready_s = ov_ready_s && !run_end_s;
                ov_valid_s   = s_data_valid && !run_end_s;
                ov_beat_s    = '{data: s_data_data, last: s_data_last, fill: 1'b0};
            end
            GAP: begin
                ov_valid_s = !gap_done_s;
                ov_beat_s  = '{data: fill_data_s, last: 1'b0, fill: 1'b1};
            end
            DONE: begin
                ts_ready_s   = !ts_done_q;
                data_ready_s = !data_done_q;
            end
            default: begin
                ts_ready_s   = 1'b0;
                data_ready_s = 1'b0;
            end
        endcase
    end

    // Control FSM; arm_q keeps the input side quiet for the first cycle after reset.
    always_ff @(posedge ps_clk) begin
        if (ps_reset) begin
            state_q        <= IDLE;
            arm_q          <= 1'b0;
            first_q        <= 1'b0;
            dec_q          <= '0;
            cur_q          <= '0;
            nxt_q          <= '0;
            cur_last_q     <= 1'b0;
            nxt_valid_q    <= 1'b0;
            nxt_last_q     <= 1'b0;
            exp_time_q     <= '0;
            sample_count_q <= '0;
            error_q        <= 1'b0;
            ts_done_q      <= 1'b0;
            data_done_q    <= 1'b0;
        end else begin
            arm_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (ts_hs_s) begin
                        dec_q          <= (cfg_decimation == '0) ? DEC_W'(1) : cfg_decimation;
                        cur_q          <= ts_in_s;
                        cur_last_q     <= s_tstamp_last;
                        nxt_valid_q    <= 1'b0;
                        exp_time_q     <= ts_in_s.time_val;
                        sample_count_q <= '0;
                        ts_done_q      <= s_tstamp_last;
                        data_done_q    <= 1'b0;
                        first_q        <= 1'b1;
                        state_q        <= PEEK;
                    end
                end
                PEEK: begin
                    exp_time_q <= cur_q.time_val;
                    if (first_q) begin
                        first_q <= 1'b0;
                        if (cur_q.index != '0) begin
                            error_q <= 1'b1;
                        end
                    end
                    if (cur_last_q) begin
                        state_q <= PASS;
                    end else if (ts_hs_s) begin
                        nxt_q       <= ts_in_s;
                        nxt_valid_q <= 1'b1;
                        nxt_last_q  <= s_tstamp_last;
                        ts_done_q   <= s_tstamp_last;
                        state_q     <= PASS;
                    end
                end
                PASS: begin
                    if (run_end_s) begin
                        state_q <= GAP;
                    end else if (data_hs_s) begin
                        sample_count_q <= count_inc_s;
                        exp_time_q     <= exp_time_q + dec_time_s;
                        if (s_data_last) begin
                            data_done_q <= 1'b1;
                            if (nxt_valid_q && (count_inc_s < nxt_q.index)) begin
                                error_q <= 1'b1;
                            end
                            state_q <= DONE;
                        end else if (nxt_valid_q && (count_inc_s == nxt_q.index)) begin
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_done_s) begin
                        if (gap_bad_s) begin
                            error_q <= 1'b1;
                        end
                        cur_q       <= nxt_q;
                        cur_last_q  <= nxt_last_q;
                        nxt_valid_q <= 1'b0;
                        state_q     <= PEEK;
                    end else if (ov_ready_s) begin
                        exp_time_q <= exp_time_q + dec_time_s;
                    end
                end
                DONE: begin
                    if (data_hs_s && s_data_last) begin
                        data_done_q <= 1'b1;
                    end
                    if (ts_hs_s && s_tstamp_last) begin
                        ts_done_q <= 1'b1;
                    end
                    if (data_done_q && ts_done_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sample_reconstructor_out_reg u_out_reg (
        .clk_i       (ps_clk),
        .rst_i       (ps_reset),
        .in_valid_i  (ov_valid_s),
        .in_beat_i   (ov_beat_s),
        .in_ready_o  (ov_ready_s),
        .out_valid_o (m_data_valid),
        .out_beat_o  (out_beat_s),
        .out_ready_i (m_data_ready)
    );
endmodule

// File: tb/tb_sample_reconstructor.sv
// Scoreboard bench for sample_reconstructor: directed streams, queued expectations, decoupled monitor.
module tb_sample_reconstructor;
    import buffer_pkg::*;

    localparam int DW    = rx_pkg::DATA_WIDTH;
    localparam int SW    = rx_pkg::SAMPLE_WIDTH;
    localparam int NS    = rx_pkg::PARALLEL_SAMPLES;
    localparam int TW    = TIME_WIDTH;
    localparam int IW    = SAMPLE_INDEX_WIDTH;
    localparam int DEC_W = $clog2(64+1);
    localparam int LIMIT = 3000;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          fill;
    } exp_t;

    logic                    ps_clk = 1'b0;
    logic                    ps_reset = 1'b1;
    logic [DEC_W-1:0]        cfg_decimation = '0;
    logic [TSTAMP_WIDTH-1:0] s_tstamp_data = '0;
    logic                    s_tstamp_valid = 1'b0;
    logic                    s_tstamp_last = 1'b0;
    logic                    s_tstamp_ready;
    logic [DW-1:0]           s_data_data = '0;
    logic                    s_data_valid = 1'b0;
    logic                    s_data_last = 1'b0;
    logic                    s_data_ready;
    logic [DW-1:0]           m_data_data;
    logic                    m_data_valid;
    logic                    m_data_last;
    logic                    m_data_fill;
    logic                    m_data_ready = 1'b1;
    logic                    error;

    exp_t          sb_q[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit            sb_en = 1'b0;
    bit            bp_en = 1'b0;
    bit            seen_valid = 1'b0;
    bit            ts_seen = 1'b0;
    int            first_valid_cyc = 0;
    int            ts_hs_cyc = 0;
    int            tid = 0;
    logic [DW-1:0] last_pass = '0;
    tstamp_t       ts_tab[4];

    sample_reconstructor #(.MAX_DECIMATION(64)) dut (
        .ps_clk         (ps_clk),
        .ps_reset       (ps_reset),
        .cfg_decimation (cfg_decimation),
        .s_tstamp_data  (s_tstamp_data),
        .s_tstamp_valid (s_tstamp_valid),
        .s_tstamp_last  (s_tstamp_last),
        .s_tstamp_ready (s_tstamp_ready),
        .s_data_data    (s_data_data),
        .s_data_valid   (s_data_valid),
        .s_data_last    (s_data_last),
        .s_data_ready   (s_data_ready),
        .m_data_data    (m_data_data),
        .m_data_valid   (m_data_valid),
        .m_data_last    (m_data_last),
        .m_data_fill    (m_data_fill),
        .m_data_ready   (m_data_ready),
        .error          (error)
    );

    always #5 ps_clk = ~ps_clk;

    always @(posedge ps_clk) cyc <= cyc + 1;

    always @(posedge ps_clk) begin
        #1;
        m_data_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic logic [DW-1:0] data_val(input int t, input int k);
        return {16'(t), 16'(k), 16'hC0DE, 16'(k * 3 + 1)};
    endfunction

    function automatic logic [DW-1:0] fill_val();
        logic [DW-1:0] r;
        r = '0;
`ifdef SAMPLE_RECONSTRUCTOR_HOLD_EN
        for (int i = 0; i < NS; i++) r[i*SW +: SW] = last_pass[DW-1 -: SW];
`endif
        return r;
    endfunction

    function automatic tstamp_t mk_ts(input logic [TW-1:0] t, input int idx);
        tstamp_t r;
        r.time_val = t;
        r.index    = IW'(idx);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a beat leaves at the next rising edge when valid and ready are both high here.
    always @(negedge ps_clk) begin
        exp_t e;
        if (!ps_reset && m_data_valid && !seen_valid) begin
            seen_valid      = 1'b1;
            first_valid_cyc = cyc;
        end
        if (!ps_reset && sb_en && m_data_valid && m_data_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat: got data=%h last=%b fill=%b with empty queue",
                         m_data_data, m_data_last, m_data_fill);
            end else begin
                e = sb_q.pop_front();
                if ({m_data_data, m_data_last, m_data_fill} !== e) begin
                    failures++;
                    $display("FAIL beat: got data=%h last=%b fill=%b expected data=%h last=%b fill=%b",
                             m_data_data, m_data_last, m_data_fill, e.data, e.last, e.fill);
                end
            end
        end
    end

    task automatic exp_pass(input int k, input logic last);
        exp_t e;
        e.data = data_val(tid, k);
        e.last = last;
        e.fill = 1'b0;
        sb_q.push_back(e);
        last_pass = e.data;
    endtask

    task automatic exp_fill(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = fill_val();
            e.last = 1'b0;
            e.fill = 1'b1;
            sb_q.push_back(e);
        end
    endtask

    task automatic ts_push(input tstamp_t t, input logic last);
        int n;
        n = 0;
        s_tstamp_data  = t;
        s_tstamp_last  = last;
        s_tstamp_valid = 1'b1;
        @(negedge ps_clk);
        while (!s_tstamp_ready && n < LIMIT) begin
            @(negedge ps_clk);
            n++;
        end
        if (!s_tstamp_ready) begin
            checks++;
            failures++;
            $display("FAIL ts_timeout: got ready=0 expected ready=1 within %0d cycles", LIMIT);
        end else if (!ts_seen) begin
            ts_seen   = 1'b1;
            ts_hs_cyc = cyc;
        end
        @(posedge ps_clk);
        #1;
        s_tstamp_valid = 1'b0;
        s_tstamp_last  = 1'b0;
    endtask

    task automatic data_push(input logic [DW-1:0] d, input logic last);
        int n;
        n = 0;
        s_data_data  = d;
        s_data_last  = last;
        s_data_valid = 1'b1;
        @(negedge ps_clk);
        while (!s_data_ready && n < LIMIT) begin
            @(negedge ps_clk);
            n++;
        end
        if (!s_data_ready) begin
            checks++;
            failures++;
            $display("FAIL data_timeout: got ready=0 expected ready=1 within %0d cycles", LIMIT);
        end
        @(posedge ps_clk);
        #1;
        s_data_valid = 1'b0;
        s_data_last  = 1'b0;
    endtask

    task automatic reset_dut();
        @(posedge ps_clk);
        #1;
        ps_reset = 1'b1;
        @(posedge ps_clk);
        #1;
        ps_reset   = 1'b0;
        sb_q.delete();
        seen_valid = 1'b0;
        ts_seen    = 1'b0;
        last_pass  = '0;
    endtask

    task automatic run_stream(input int n_ts, input int n_data, input logic data_last);
        fork
            begin
                for (int i = 0; i < n_ts; i++) ts_push(ts_tab[i], (i == n_ts - 1));
            end
            begin
                for (int k = 0; k < n_data; k++) data_push(data_val(tid, k), data_last && (k == n_data - 1));
            end
        join
    endtask

    task automatic finish_test(input string name, input logic exp_err);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < LIMIT) begin
            @(negedge ps_clk);
            n++;
        end
        chk({name, "_drain"}, 64'(sb_q.size()), 64'd0);
        n = 0;
        @(negedge ps_clk);
        while (!s_tstamp_ready && n < 20) begin
            @(negedge ps_clk);
            n++;
        end
        chk({name, "_idle"}, {62'd0, s_tstamp_ready, s_data_ready}, 64'd2);
        chk({name, "_error"}, 64'(error), 64'(exp_err));
    endtask

    initial begin
        logic [TW-1:0] t_wrap;
        int n;

        repeat (3) @(posedge ps_clk);
        #1;
        ps_reset = 1'b0;
        reset_dut();
        chk("rst_m_valid", 64'(m_data_valid), 64'd0);
        chk("rst_m_last", 64'(m_data_last), 64'd0);
        chk("rst_m_fill", 64'(m_data_fill), 64'd0);
        chk("rst_m_data", m_data_data, 64'd0);
        chk("rst_ts_ready", 64'(s_tstamp_ready), 64'd0);
        chk("rst_data_ready", 64'(s_data_ready), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        sb_en = 1'b1;

        // Contiguous run, single timestamp with last.
        tid = 1;
        cfg_decimation = DEC_W'(1);
        reset_dut();
        ts_tab[0] = mk_ts(TW'(100), 0);
        for (int k = 0; k < 8; k++) exp_pass(k, (k == 7));
        run_stream(1, 8, 1'b1);
        finish_test("contig", 1'b0);
        chk("first_latency", 64'(first_valid_cyc - ts_hs_cyc), 64'd3);

        // Two runs separated by a six-batch gap.
        tid = 2;
        reset_dut();
        ts_tab[0] = mk_ts(TW'(100), 0);
        ts_tab[1] = mk_ts(TW'(110), 4);
        for (int k = 0; k < 4; k++) exp_pass(k, 1'b0);
        exp_fill(6);
        exp_pass(4, 1'b0);
        exp_pass(5, 1'b1);
        run_stream(2, 6, 1'b1);
        finish_test("gap", 1'b0);

        // Decimation 4: exp after two batches is 8, gap to 20 is three batches.
        tid = 3;
        cfg_decimation = DEC_W'(4);
        reset_dut();
        ts_tab[0] = mk_ts(TW'(0), 0);
        ts_tab[1] = mk_ts(TW'(20), 2);
        exp_pass(0, 1'b0);
        exp_pass(1, 1'b0);
        exp_fill(3);
        exp_pass(2, 1'b1);
        run_stream(2, 3, 1'b1);
        finish_test("dec4", 1'b0);

        // Time wrap: start at 2^TW-2, two batches land on 0, gap to 3.
        tid = 4;
        cfg_decimation = DEC_W'(1);
        reset_dut();
        t_wrap = '1;
        t_wrap = t_wrap - TW'(1);
        ts_tab[0] = mk_ts(t_wrap, 0);
        ts_tab[1] = mk_ts(TW'(3), 2);
        exp_pass(0, 1'b0);
        exp_pass(1, 1'b0);
        exp_fill(3);
        exp_pass(2, 1'b1);
        run_stream(2, 3, 1'b1);
        finish_test("wrap", 1'b0);

        // Overlap: next run starts before exp_time, no fill, stream continues.
        tid = 5;
        reset_dut();
        ts_tab[0] = mk_ts(TW'(100), 0);
        ts_tab[1] = mk_ts(TW'(102), 4);
        for (int k = 0; k < 6; k++) exp_pass(k, (k == 5));
        run_stream(2, 6, 1'b1);
        finish_test("overlap", 1'b1);

        // Early data last before index 4 is reached.
        tid = 6;
        reset_dut();
        ts_tab[0] = mk_ts(TW'(0), 0);
        ts_tab[1] = mk_ts(TW'(10), 4);
        exp_pass(0, 1'b0);
        exp_pass(1, 1'b1);
        run_stream(2, 2, 1'b1);
        finish_test("early_last", 1'b1);

        // Two-run case again under random output backpressure.
        tid = 7;
        reset_dut();
        bp_en = 1'b1;
        ts_tab[0] = mk_ts(TW'(100), 0);
        ts_tab[1] = mk_ts(TW'(110), 4);
        for (int k = 0; k < 4; k++) exp_pass(k, 1'b0);
        exp_fill(6);
        exp_pass(4, 1'b0);
        exp_pass(5, 1'b1);
        run_stream(2, 6, 1'b1);
        finish_test("backpressure", 1'b0);
        bp_en = 1'b0;

        // Reset pulse while a long gap is being filled.
        tid = 8;
        sb_en = 1'b0;
        reset_dut();
        ts_tab[0] = mk_ts(TW'(0), 0);
        ts_tab[1] = mk_ts(TW'(1000), 2);
        run_stream(2, 2, 1'b0);
        n = 0;
        @(negedge ps_clk);
        while (!(m_data_valid && m_data_fill) && n < 50) begin
            @(negedge ps_clk);
            n++;
        end
        chk("gap_reached", 64'(m_data_valid && m_data_fill), 64'd1);
        repeat (5) @(negedge ps_clk);
        reset_dut();
        chk("midgap_m_valid", 64'(m_data_valid), 64'd0);
        chk("midgap_m_fill", 64'(m_data_fill), 64'd0);
        chk("midgap_m_data", m_data_data, 64'd0);
        chk("midgap_flags", {60'd0, m_data_last, s_tstamp_ready, s_data_ready, error}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
